// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving the CPU port (m0) and the debug port (m1) turns on one sync-read data memory.
// Latency: request sampled in IDLE -> memory strobe next cycle -> ack the cycle after. One access per 3 cycles.
// Backpressure: a requester holds req until its one-cycle ack; inputs are latched at grant.
module dm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              gnt;
    logic              last_gnt;
    logic              pick;
    logic              any_req;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    assign any_req = m0_req_i | m1_req_i;

    // On a tie the port that did not own the previous access wins.
    always_comb begin
        pick      = m1_req_i;
        state_nxt = state;
        if (m0_req_i && m1_req_i) begin
            pick = ~last_gnt;
        end
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                gnt       <= pick;
                lat_we    <= pick ? m1_we_i    : m0_we_i;
                lat_addr  <= pick ? m1_addr_i  : m0_addr_i;
                lat_wdata <= pick ? m1_wdata_i : m0_wdata_i;
            end
            if (state == RESP) begin
                last_gnt <= gnt;
                if (!lat_we) begin
                    if (gnt) rdata1 <= mem_rdata_i;
                    else     rdata0 <= mem_rdata_i;
                end
            end
        end
    end

    // Read data is forwarded straight from memory during RESP, then held in rdata0/1.
    always_comb begin
        mem_en_o    = (state == ACCESS);
        mem_we_o    = (state == ACCESS) && lat_we;
        mem_addr_o  = lat_addr;
        mem_wdata_o = lat_wdata;
        m0_ack_o    = (state == RESP) && !gnt;
        m1_ack_o    = (state == RESP) && gnt;
        m0_rdata_o  = rdata0;
        m1_rdata_o  = rdata1;
        if (m0_ack_o && !lat_we) m0_rdata_o = mem_rdata_i;
        if (m1_ack_o && !lat_we) m1_rdata_o = mem_rdata_i;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural sync-read memory, transaction table, scoreboard on acks.
module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          ack_cnt = 0;
    exp_t        sb[$];
    longint      ack_t[$];
    logic [31:0] last_rd [2];

    logic [31:0] mem [0:63];
    logic [63:0] wr = '0;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unwritten words read back as a fixed pattern; word 0x8 holds 0x1234.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a[7:0] == 8'h08) return 32'h0000_1234;
        return {16'hC0DE, 8'h00, a[7:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:2]] <= mem_wdata;
                wr[mem_addr[7:2]]  <= 1'b1;
            end else begin
                mem_rdata <= wr[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_word(mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack)) begin
            ack_cnt++;
            ack_t.push_back(longint'($time));
            chk("single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack m0_ack=%0b m1_ack=%0b required none", m0_ack, m1_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {31'b0, m1_ack}, 32'(e.port));
                chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic push_exp(input int p, input logic we, input logic [31:0] exp);
        exp_t e;
        e.port  = p;
        e.rdata = we ? last_rd[p] : exp;
        if (!we) last_rd[p] = exp;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_acks"}, {30'b0, m1_ack, m0_ack}, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    endtask

    // Single isolated access: checks the memory strobe cycle and the ack latency.
    task automatic do_txn(input vec_t v);
        bit got = 0;
        int lat = -1;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        push_exp(v.port, v.we, v.exp);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("strobe_en", {31'b0, mem_en}, 32'd1);
                chk("strobe_we", {31'b0, mem_we}, {31'b0, v.we});
                chk("strobe_addr", mem_addr, v.addr);
                if (v.we) chk("strobe_wdata", mem_wdata, v.wdata);
            end
            if ((v.port == 0 && m0_ack) || (v.port == 1 && m1_ack)) begin
                got = 1;
                lat = c;
                break;
            end
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        chk("ack_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        drive(v.port, 1'b0, 1'b0, v.addr, v.wdata);
    endtask

    // Both ports request reads and hold req until n acks have been seen; m0 is expected first.
    task automatic both_run(input int n, input logic [31:0] a0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [31:0] d1);
        int start;
        int nt;
        @(posedge clk); #1;
        start = ack_cnt;
        nt    = ack_t.size();
        drive(0, 1'b1, 1'b0, a0, 32'd0);
        drive(1, 1'b1, 1'b0, a1, 32'd0);
        for (int i = 0; i < n; i++) push_exp(i % 2, 1'b0, (i % 2 == 0) ? d0 : d1);
        for (int c = 0; c < 3 * n + 8; c++) begin
            @(negedge clk); #1;
            if (ack_cnt - start >= n) break;
        end
        drive(0, 1'b0, 1'b0, a0, 32'd0);
        drive(1, 1'b0, 1'b0, a1, 32'd0);
        chk("both_ack_count", 32'(ack_cnt - start), 32'(n));
        if (ack_t.size() >= nt + n) begin
            for (int i = 1; i < n; i++)
                chk("ack_spacing", 32'(ack_t[nt + i] - ack_t[nt + i - 1]), 32'd30);
        end
    endtask

    vec_t vecs [8];

    initial begin
        int n0;
        bit saw_en;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit saw_en;
        vecs[0] = '{0, 1'b0, 32'h08, 32'h0,         32'h0000_1234};
        vecs[1] = '{1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1, 1'b0, 32'h0C, 32'h0,         32'hC0DE_000C};
        vecs[4] = '{0, 1'b1, 32'h20, 32'h5555_AAAA, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h20, 32'h0,         32'h5555_AAAA};
        vecs[6] = '{0, 1'b1, 32'h0C, 32'h0BAD_F00D, 32'h0};
        vecs[7] = '{0, 1'b0, 32'h0C, 32'h0,         32'h0BAD_F00D};

        rst_n = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i]);
            if (i == 0) begin
                repeat (10) @(negedge clk);
                chk("m0_rdata_hold", m0_rdata, 32'h0000_1234);
            end
            if (i == 1) chk("m1_rdata_after_write", m1_rdata, 32'h0);
            if (i == 6) chk("m0_rdata_after_write", m0_rdata, 32'hDEAD_BEEF);
        end

        // m0 drops req and changes addr while its access is in flight.
        @(posedge clk); #1;
        n0 = ack_cnt;
        drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
        push_exp(0, 1'b0, 32'h0000_1234);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h04, 32'h0);
        @(negedge clk);
        chk("drop_strobe_en", {31'b0, mem_en}, 32'd1);
        chk("drop_latched_addr", mem_addr, 32'h08);
        @(negedge clk);
        chk("drop_ack", {31'b0, m0_ack}, 32'd1);
        saw_en = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_en) saw_en = 1;
        end
        chk("drop_no_regrant", {31'b0, saw_en}, 32'd0);
        chk("drop_single_ack", 32'(ack_cnt - n0), 32'd1);

        // m1 alone three times, then both: m0 must win the tie.
        for (int i = 0; i < 3; i++) do_txn('{1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF});
        both_run(2, 32'h08, 32'h0000_1234, 32'h20, 32'h5555_AAAA);

        // From reset, both hold req: strict alternation starting at m0.
        do_reset();
        both_run(4, 32'h08, 32'h0000_1234, 32'h20, 32'h5555_AAAA);

        // Reset during ACCESS aborts the access without an ack.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_access", {31'b0, mem_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk_outputs_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b1;
        n0 = ack_cnt;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_ack", 32'(ack_cnt - n0), 32'd0);
        do_txn('{1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF});

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter that shares the single-ported, synchronous-read data memory between the CPU load/store port (m0) and a debug/loader port (m1). It owns the memory control signals, serialises accesses through a 3-state FSM and applies round-robin fairness. It sits between Simple_Single_CPU's load/store path plus the debug master, and the Data_Memory array.

Parameters:
ADDR_W, 32, byte address width of both requesters and the memory port
DATA_W, 32, data word width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset
m0_req_i  in  1  m0 access request; held high until m0_ack_o
m0_we_i  in  1  m0 write (1) / read (0)
m0_addr_i  in  ADDR_W  m0 address
m0_wdata_i  in  DATA_W  m0 write data
m0_ack_o  out  1  one-cycle completion pulse to m0
m0_rdata_o  out  DATA_W  m0 read data
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o  same as m0, for m1
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_en_o=1 with mem_we_o=0

Behaviour:
- States: IDLE, ACCESS, RESP. Registers: state, gnt (owner of the current access), last_gnt, latched we/addr/wdata, rdata0, rdata1.
- Reset (rst_i=0, takes effect immediately, independent of clk_i): state=IDLE, last_gnt=1 (so m0 wins the first tie), latched addr/wdata/we=0, rdata0=rdata1=0. All outputs 0.
- IDLE: no request -> stay. Exactly one req high -> grant it. Both high -> grant the port != last_gnt. On grant: latch that port's we/addr/wdata, set gnt, go to ACCESS.
- ACCESS (1 cycle): mem_en_o=1; mem_we_o/mem_addr_o/mem_wdata_o driven from the latched values. Go to RESP.
- RESP (1 cycle): mx_ack_o=1 for the granted port only. For a read, mx_rdata_o = mem_rdata_i combinationally in this cycle, and rdatax captures mem_rdata_i at the closing edge. last_gnt<=gnt. Go to IDLE.
- Outside its own RESP cycle, mx_rdata_o = rdatax; it holds the last read value until the port's next read completes. Writes never change rdatax.
- mem_en_o and mem_we_o are 0 in IDLE and RESP. mem_addr_o and mem_wdata_o hold the latched values in all states.
- Latency: req sampled high at edge N (in IDLE) -> ACCESS in cycle N+1 -> ack in cycle N+2. Maximum throughput is one access per 3 cycles.
- Requester rule: keep req, we, addr and wdata stable until ack. Requester inputs are latched at grant, so later changes do not affect the in-flight access.
- Req dropped before ack: the access still completes and ack still pulses; the requester ignores it.
- Req still high in the cycle after ack: treated as a new request and re-arbitrated in IDLE, so the other port wins if it is requesting.
- Starvation bound: with both ports requesting continuously, grants alternate and each port waits at most one foreign access (3 cycles).
- Reset mid-ACCESS or mid-RESP: the access is aborted, no ack is produced, and the FSM restarts in IDLE once rst_i=1. A memory write already strobed during ACCESS may have completed.
- Never both acks in the same cycle. Never an ack outside RESP.

Test Plan:
1. Reset then m0 read at addr 0x8, memory word 0x8 = 0x0000_1234 -> mem_en_o=1 and mem_we_o=0 in cycle N+1; m0_ack_o=1 and m0_rdata_o=0x1234 in cycle N+2; m1_ack_o stays 0; m0_rdata_o still 0x1234 10 cycles later.
2. m1 write addr 0x10 data 0xDEAD_BEEF -> mem_we_o=1, mem_addr_o=0x10, mem_wdata_o=0xDEADBEEF in cycle N+1; m1_ack_o in N+2; m1_rdata_o unchanged (0); a later m0 read of 0x10 returns 0xDEADBEEF.
3. Both ports request from reset and hold req -> ack order m0, m1, m0, m1, with acks spaced exactly 3 cycles apart.
4. m1 requests alone for 3 accesses, then both request -> m0 is granted next (last_gnt=1), then m1.
5. Assert rst_i=0 during ACCESS of an m0 read -> all outputs 0 immediately; no ack ever issued for that access; a fresh m1 request after release completes with ack 2 cycles after sampling.
6. m0 drops req one cycle after grant and changes addr to 0x4 -> mem_addr_o keeps the originally latched address; m0_ack_o still pulses once; the FSM returns to IDLE with no further grant.
